rgb_wb_gain: RTL

//  Per-channel white-balance gain stage directly downstream of the debayer. Takes 12-bit RGB

---
 rtl/rgb_wb_gain.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/rgb_wb_gain.sv
// Per-channel white-balance gain for 12-bit RGB video: frame-synchronous U2.8 gains,
// round/saturate/truncate to OUT_W bits with 3-cycle aligned syncs, plus frame geometry checking.
module rgb_wb_gain #(
  parameter int unsigned OUT_W    = 8,
  parameter int unsigned H_ACTIVE = 1920,
  parameter int unsigned V_ACTIVE = 1080
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             vsync_in,
  input  logic             hsync_in,
  input  logic             de_in,
  input  logic [11:0]      rin,
  input  logic [11:0]      gin,
  input  logic [11:0]      bin,
  input  logic [9:0]       gain_r,
  input  logic [9:0]       gain_g,
  input  logic [9:0]       gain_b,
  input  logic             gain_load,
  input  logic             err_clr,
  output logic             vsync,
  output logic             hsync,
  output logic             de,
  output logic [OUT_W-1:0] rout,
  output logic [OUT_W-1:0] gout,
  output logic [OUT_W-1:0] bout,
  output logic [15:0]      frame_cnt,
  output logic             geom_err
);

  localparam int unsigned PIX_W  = 12;
  localparam int unsigned GAIN_W = 10;
  localparam int unsigned PROD_W = PIX_W + GAIN_W;
  localparam int unsigned Q_W    = PROD_W - 8;
  localparam int unsigned CNT_W  = 12;
  localparam int unsigned FC_W   = 16;
  localparam logic [GAIN_W-1:0] UNITY   = GAIN_W'(256);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [PIX_W-1:0]  PIX_MAX = '1;

  // Channel index 2 = red, 1 = green, 0 = blue throughout.
  logic [2:0][GAIN_W-1:0] gain_in_c;
  logic [2:0][PIX_W-1:0]  pix_in_c;
  assign gain_in_c = {gain_r, gain_g, gain_b};
  assign pix_in_c  = {rin, gin, bin};

  logic [2:0][GAIN_W-1:0] act_q, act_d, pend_q, pend_d;
  logic                   pend_vld_q, pend_vld_d;

  logic [2:0][PIX_W-1:0]  s1_pix_q;
  logic [2:0]             s1_sync_q;     // {vsync, hsync, de}
  logic [2:0][PROD_W-1:0] s2_prod_q, s2_prod_d;
  logic [2:0]             s2_sync_q;
  logic [2:0][OUT_W-1:0]  s3_pix_q, s3_pix_d;
  logic [2:0]             s3_sync_q;

  logic [CNT_W-1:0] pix_run_q, pix_run_d, line_run_q, line_run_d;
  logic             synced_q, synced_d, err_q, err_d, err_set_c;
  logic [FC_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic vs_rise_c, de_fall_c;
  // Stage-1 sync registers double as the previous-cycle input history.
  assign vs_rise_c = vsync_in & ~s1_sync_q[2];
  assign de_fall_c = ~de_in & s1_sync_q[0];

  // Gains: pending captured on load, promoted to active only on a vsync rise.
  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    act_d      = act_q;
    if (gain_load) begin
      pend_d     = gain_in_c;
      pend_vld_d = 1'b1;
    end
    if (vs_rise_c && (gain_load || pend_vld_q)) begin
      act_d      = gain_load ? gain_in_c : pend_q;
      pend_vld_d = 1'b0;
    end
  end

  // Multiply, then round, saturate and keep the MSBs.
  always_comb begin
    logic [PROD_W-1:0] sum;
    logic [Q_W-1:0]    q;
    logic [PIX_W-1:0]  sat;
    s2_prod_d = '0;
    s3_pix_d  = '0;
    for (int i = 0; i < 3; i++) begin
      s2_prod_d[i] = PROD_W'(s1_pix_q[i]) * PROD_W'(act_q[i]);
      sum = s2_prod_q[i] + PROD_W'(128);
      q   = Q_W'(sum >> 8);
      sat = (q > Q_W'(PIX_MAX)) ? PIX_MAX : PIX_W'(q);
      s3_pix_d[i] = s2_sync_q[0] ? OUT_W'(sat >> (PIX_W - OUT_W)) : '0;
    end
  end

  // Geometry checker on the input-side de/vsync.
  always_comb begin
    pix_run_d   = '0;
    line_run_d  = line_run_q;
    synced_d    = synced_q;
    frame_cnt_d = frame_cnt_q;
    err_set_c   = 1'b0;
    if (de_in) begin
      pix_run_d = (pix_run_q == CNT_MAX) ? pix_run_q : pix_run_q + CNT_W'(1);
    end
    if (de_fall_c) begin
      if (synced_q && (pix_run_q != CNT_W'(H_ACTIVE))) err_set_c = 1'b1;
      if (line_run_q != CNT_MAX) line_run_d = line_run_q + CNT_W'(1);
    end
    if (vs_rise_c) begin
      if (synced_q && (line_run_q != CNT_W'(V_ACTIVE))) err_set_c = 1'b1;
      line_run_d  = '0;
      synced_d    = 1'b1;
      frame_cnt_d = frame_cnt_q + FC_W'(1);
    end
    err_d = err_clr ? 1'b0 : (err_q | err_set_c);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      act_q       <= {3{UNITY}};
      pend_q      <= {3{UNITY}};
      pend_vld_q  <= 1'b0;
      s1_pix_q    <= '0;
      s1_sync_q   <= '0;
      s2_prod_q   <= '0;
      s2_sync_q   <= '0;
      s3_pix_q    <= '0;
      s3_sync_q   <= '0;
      pix_run_q   <= '0;
      line_run_q  <= '0;
      synced_q    <= 1'b0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      s1_pix_q    <= pix_in_c;
      s1_sync_q   <= {vsync_in, hsync_in, de_in};
      s2_prod_q   <= s2_prod_d;
      s2_sync_q   <= s1_sync_q;
      s3_pix_q    <= s3_pix_d;
      s3_sync_q   <= s2_sync_q;
      pix_run_q   <= pix_run_d;
      line_run_q  <= line_run_d;
      synced_q    <= synced_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign vsync     = s3_sync_q[2];
  assign hsync     = s3_sync_q[1];
  assign de        = s3_sync_q[0];
  assign rout      = s3_pix_q[2];
  assign gout      = s3_pix_q[1];
  assign bout      = s3_pix_q[0];
  assign frame_cnt = frame_cnt_q;
  assign geom_err  = err_q;

endmodule
